// File: rtl/camera_ray_gen.sv
// Primary-ray generator: walks a WIDTH x HEIGHT frame in raster order and emits one
// {origin, direction} ray per pixel, building directions with adders only.
module camera_ray_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [83:0]     cam_orig,
    input  logic [83:0]     dir_base,
    input  logic [83:0]     du,
    input  logic [83:0]     dv,
    output logic [167:0]    ray_out,
    output logic            ray_valid,
    input  logic            ray_ready,
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic            last,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    // Vectors pack as {x, y, z}, 28-bit Q12.16 each; every lane wraps independently.
    function automatic logic [83:0] vadd(input logic [83:0] a, input logic [83:0] b);
        vadd = {a[83:56] + b[83:56], a[55:28] + b[55:28], a[27:0] + b[27:0]};
    endfunction

    state_t          state_q;
    logic [83:0]     orig_q;
    logic [83:0]     du_q;
    logic [83:0]     dv_q;
    logic [83:0]     row_dir_q;
    logic [83:0]     cur_dir_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic            last_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    logic [83:0]     row_dir_d;
    logic [83:0]     cur_dir_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic            row_wrap;
    logic            fire;

    // Stream handshake: a ray transfers on any rising edge where ray_valid and ray_ready
    // are both high; while valid is high and ready is low every payload bit is held.
    // Ready without valid has no effect, and valid never depends on ready.
    always_comb begin
        fire      = valid_q & ray_ready;
        row_wrap  = (x_q == X_MAX);
        row_dir_d = vadd(row_dir_q, dv_q);
        cur_dir_d = vadd(cur_dir_q, du_q);
        x_d       = row_wrap ? '0 : x_q + XW'(1);
        y_d       = row_wrap ? y_q + YW'(1) : y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            orig_q    <= '0;
            du_q      <= '0;
            dv_q      <= '0;
            row_dir_q <= '0;
            cur_dir_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        orig_q    <= cam_orig;
                        du_q      <= du;
                        dv_q      <= dv;
                        row_dir_q <= dir_base;
                        cur_dir_q <= dir_base;
                        x_q       <= '0;
                        y_q       <= '0;
                        last_q    <= (X_MAX == '0) && (Y_MAX == '0);
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (fire) begin
                        if (last_q) begin
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            x_q    <= x_d;
                            y_q    <= y_d;
                            last_q <= (x_d == X_MAX) && (y_d == Y_MAX);
                            // A row wrap restarts the column walk from the next row base.
                            if (row_wrap) begin
                                row_dir_q <= row_dir_d;
                                cur_dir_q <= row_dir_d;
                            end else begin
                                cur_dir_q <= cur_dir_d;
                            end
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ray_out     = {orig_q, cur_dir_q};
    assign ray_valid   = valid_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign last        = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_camera_ray_gen.sv
// Directed bench for camera_ray_gen: four frame geometries (4x3, 2x1, 1x1, 1x3)
// checked against hand values and a multiply-based direction model.
module tb_camera_ray_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [83:0] cam_orig, dir_base, du, dv;
    logic        ray_ready;
    logic        start_a, start_b, start_c, start_d;

    logic [167:0] ray_out_a, ray_out_b, ray_out_c, ray_out_d;
    logic         ray_valid_a, ray_valid_b, ray_valid_c, ray_valid_d;
    logic [1:0]   pix_x_a, pix_y_a, pix_y_d;
    logic         pix_x_b, pix_y_b, pix_x_c, pix_y_c, pix_x_d;
    logic         last_a, last_b, last_c, last_d;
    logic         busy_a, busy_b, busy_c, busy_d;
    logic         done_a, done_b, done_c, done_d;
    logic [1:0]   st_a, st_b, st_c, st_d;

    camera_ray_gen #(.WIDTH(4), .HEIGHT(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .cam_orig(cam_orig), .dir_base(dir_base),
        .du(du), .dv(dv), .ray_out(ray_out_a), .ray_valid(ray_valid_a), .ray_ready(ray_ready),
        .pix_x(pix_x_a), .pix_y(pix_y_a), .last(last_a), .busy(busy_a), .done(done_a),
        .dbg_state_o(st_a));

    camera_ray_gen #(.WIDTH(2), .HEIGHT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .cam_orig(cam_orig), .dir_base(dir_base),
        .du(du), .dv(dv), .ray_out(ray_out_b), .ray_valid(ray_valid_b), .ray_ready(ray_ready),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .last(last_b), .busy(busy_b), .done(done_b),
        .dbg_state_o(st_b));

    camera_ray_gen #(.WIDTH(1), .HEIGHT(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .cam_orig(cam_orig), .dir_base(dir_base),
        .du(du), .dv(dv), .ray_out(ray_out_c), .ray_valid(ray_valid_c), .ray_ready(ray_ready),
        .pix_x(pix_x_c), .pix_y(pix_y_c), .last(last_c), .busy(busy_c), .done(done_c),
        .dbg_state_o(st_c));

    camera_ray_gen #(.WIDTH(1), .HEIGHT(3)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .cam_orig(cam_orig), .dir_base(dir_base),
        .du(du), .dv(dv), .ray_out(ray_out_d), .ray_valid(ray_valid_d), .ray_ready(ray_ready),
        .pix_x(pix_x_d), .pix_y(pix_y_d), .last(last_d), .busy(busy_d), .done(done_d),
        .dbg_state_o(st_d));

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [27:0] NEG1 = 28'hFFF0000;
    localparam logic [27:0] Z    = 28'd0;

    logic [83:0] m_orig, m_base, m_du, m_dv;
    logic [83:0] dir_3_2;

    task automatic check(input string tag, input logic [167:0] got, input logic [167:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [83:0] vec(input logic [27:0] x, input logic [27:0] y,
                                       input logic [27:0] z);
        return {x, y, z};
    endfunction

    // Closed form base + x*du + y*dv per lane, mod 2^28.
    function automatic logic [83:0] exp_dir(input logic [83:0] b, input logic [83:0] u,
                                            input logic [83:0] v, input int x, input int y);
        logic [83:0] r;
        for (int c = 0; c < 3; c++)
            r[c*28 +: 28] = b[c*28 +: 28] + 28'(x) * u[c*28 +: 28] + 28'(y) * v[c*28 +: 28];
        return r;
    endfunction

    task automatic set_p1();
        m_orig = vec(28'h10000, 28'h20000, Z);
        m_base = vec(Z, Z, NEG1);
        m_du   = vec(28'h4000, Z, Z);
        m_dv   = vec(Z, 28'h8000, Z);
        cam_orig = m_orig; dir_base = m_base; du = m_du; dv = m_dv;
    endtask

    task automatic set_p2();
        m_orig = vec(28'h3, 28'hFFFFFFF, 28'h100);
        m_base = vec(28'h1000, 28'hFFFF000, Z);
        m_du   = vec(28'hFFFFFFF, 28'h10, 28'h1);
        m_dv   = vec(28'h100, 28'h200, 28'hFFFFFF0);
        cam_orig = m_orig; dir_base = m_base; du = m_du; dv = m_dv;
    endtask

    task automatic scramble();
        cam_orig = {21{4'hA}}; dir_base = {21{4'h5}}; du = {21{4'h3}}; dv = {21{4'hC}};
    endtask

    task automatic launch_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        scramble();
    endtask

    // Entered at a negedge with the frame already emitting; leaves at the negedge after
    // the stop_after-th handshake.
    task automatic run_a(input bit bp, input int stop_after, input bit poke_start);
        int k = 0;
        int cyc = 0;
        logic rdy;
        while (k < stop_after && cyc < 300) begin
            check("a_valid", 168'(ray_valid_a), 168'(1));
            check("a_ray", ray_out_a, {m_orig, exp_dir(m_base, m_du, m_dv, k % 4, k / 4)});
            check("a_pix_x", 168'(pix_x_a), 168'(k % 4));
            check("a_pix_y", 168'(pix_y_a), 168'(k / 4));
            check("a_last", 168'(last_a), 168'(k == 11));
            check("a_busy", 168'(busy_a), 168'(1));
            check("a_done_early", 168'(done_a), 168'(0));
            if (k == 11) dir_3_2 = ray_out_a[83:0];
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ray_ready = rdy;
            start_a = poke_start && (k == 5);
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start_a = 1'b0;
        if (k < stop_after) check("a_timeout", 168'(k), 168'(stop_after));
    endtask

    task automatic check_fin_a();
        check("a_fin_done", 168'(done_a), 168'(1));
        check("a_fin_valid", 168'(ray_valid_a), 168'(0));
        check("a_fin_busy", 168'(busy_a), 168'(0));
        check("a_fin_state", 168'(st_a), 168'(2));
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_state"}, 168'(st_a), 168'(0));
        check({tag, "_valid"}, 168'(ray_valid_a), 168'(0));
        check({tag, "_done"}, 168'(done_a), 168'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        void'($urandom(32'd1234));
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        ray_ready = 1'b0;
        cam_orig = '0; dir_base = '0; du = '0; dv = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ray", ray_out_a, 168'(0));
        check("rst_valid", 168'(ray_valid_a), 168'(0));
        check("rst_pix", 168'({pix_x_a, pix_y_a}), 168'(0));
        check("rst_last", 168'(last_a), 168'(0));
        check("rst_busy", 168'(busy_a), 168'(0));
        check("rst_done", 168'(done_a), 168'(0));
        check("rst_state", 168'(st_a), 168'(0));
        rst = 1'b0;

        // Frame 1: full 4x3, ready high, start poked mid-frame
        set_p1();
        launch_a();
        run_a(1'b0, 12, 1'b1);
        check("a_dir_3_2", 168'(dir_3_2), 168'(vec(28'hC000, 28'h10000, NEG1)));
        check_fin_a();
        // start held across FIN (ignored) and the following IDLE cycle (accepted)
        set_p2();
        start_a = 1'b1;
        @(negedge clk);
        check_idle_a("a_fin_start");
        @(negedge clk);
        start_a = 1'b0;
        scramble();
        run_a(1'b0, 12, 1'b0);
        check_fin_a();
        @(negedge clk);
        check_idle_a("a_after2");

        // Frame 3: same frame as frame 1 under random backpressure
        set_p1();
        launch_a();
        run_a(1'b1, 12, 1'b0);
        check_fin_a();
        ray_ready = 1'b1;
        @(negedge clk);
        check_idle_a("a_after3");

        // Reset after the 5th handshake, then restart
        set_p1();
        launch_a();
        run_a(1'b0, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ray", ray_out_a, 168'(0));
        check("mid_rst_pix", 168'({pix_x_a, pix_y_a}), 168'(0));
        check("mid_rst_flags", 168'({ray_valid_a, last_a, busy_a, done_a}), 168'(0));
        check("mid_rst_state", 168'(st_a), 168'(0));
        @(negedge clk);
        check_idle_a("mid_rst_idle");
        set_p1();
        launch_a();
        run_a(1'b0, 12, 1'b0);
        check_fin_a();
        @(negedge clk);

        // 2x1 lane wrap-around
        cam_orig = vec(28'd1, 28'd2, 28'd3);
        dir_base = vec(28'h7FFFFFF, Z, Z);
        du = vec(28'd1, Z, Z);
        dv = '0;
        ray_ready = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_valid0", 168'(ray_valid_b), 168'(1));
        check("b_dir0", 168'(ray_out_b[83:0]), 168'(vec(28'h7FFFFFF, Z, Z)));
        check("b_pix0", 168'(pix_x_b), 168'(0));
        check("b_last0", 168'(last_b), 168'(0));
        @(negedge clk);
        check("b_dir1", 168'(ray_out_b[83:0]), 168'(vec(28'h8000000, Z, Z)));
        check("b_orig1", 168'(ray_out_b[167:84]), 168'(vec(28'd1, 28'd2, 28'd3)));
        check("b_pix1", 168'(pix_x_b), 168'(1));
        check("b_last1", 168'(last_b), 168'(1));
        @(negedge clk);
        check("b_done", 168'({done_b, ray_valid_b}), 168'(2'b10));

        // 1x1 single ray
        dir_base = vec(28'h123, 28'h456, 28'h789);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        check("c_valid", 168'(ray_valid_c), 168'(1));
        check("c_last", 168'(last_c), 168'(1));
        check("c_pix", 168'({pix_x_c, pix_y_c}), 168'(0));
        check("c_dir", 168'(ray_out_c[83:0]), 168'(vec(28'h123, 28'h456, 28'h789)));
        @(negedge clk);
        check("c_done", 168'({done_c, ray_valid_c}), 168'(2'b10));

        // 1x3: every handshake is a row wrap
        dir_base = '0;
        du = vec(28'd5, Z, Z);
        dv = vec(Z, 28'h10000, Z);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("d_valid", 168'(ray_valid_d), 168'(1));
            check("d_dir", 168'(ray_out_d[83:0]), 168'(vec(Z, 28'(i * 32'h10000), Z)));
            check("d_pix_y", 168'(pix_y_d), 168'(i));
            check("d_last", 168'(last_d), 168'(i == 2));
            @(negedge clk);
        end
        check("d_done", 168'({done_d, ray_valid_d}), 168'(2'b10));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
